// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: two-master round-robin arbiter onto a single-outstanding data port toward the MMU.
// Latency: grant and slave request are combinational in the request cycle; the slave response passes straight back.
// Backpressure: while a transaction is outstanding, requests are held off (not queued); masters keep req high until gnt.

package rv_pkg;
    parameter int XLEN = 32;
endpackage

module rv_mem_arbiter
    import rv_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [XLEN/8-1:0] m0_be_i,
    input  logic [XLEN-1:0]   m0_addr_i,
    input  logic [XLEN-1:0]   m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [XLEN-1:0]   m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [XLEN/8-1:0] m1_be_i,
    input  logic [XLEN-1:0]   m1_addr_i,
    input  logic [XLEN-1:0]   m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [XLEN-1:0]   m1_rdata_o,

    output logic              data_req_o,
    output logic              data_we_o,
    output logic [XLEN/8-1:0] data_be_o,
    output logic [XLEN-1:0]   data_addr_o,
    output logic [XLEN-1:0]   data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [XLEN-1:0]   data_rdata_i,

    output logic              err_o
);

    // Counter value at which an unanswered transaction is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;   // master that owns the outstanding transaction
    logic            last_q,  last_d;    // master granted most recently
    logic [7:0]      cnt_q,   cnt_d;     // BUSY cycles spent without a response

    logic            win;                // master selected this cycle
    logic            grant;
    logic            rsp;                // response (real or timeout) delivered to owner
    logic [XLEN-1:0] rsp_data;
    logic            err;
    logic            live;

    // State, ownership, fairness and timeout registers; reset clears them asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Arbitration, response routing and timeout decision for the current cycle.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        win      = 1'b0;
        grant    = 1'b0;
        rsp      = 1'b0;
        rsp_data = '0;
        err      = 1'b0;
        case (state_q)
            IDLE: begin
                // Nothing is outstanding, so any response here is stale.
                if (data_rvalid_i) begin
                    err = 1'b1;
                end
                if (m0_req_i || m1_req_i) begin
                    // On contention the master not granted last time wins.
                    win     = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
                    grant   = 1'b1;
                    owner_d = win;
                    last_d  = win;
                    cnt_d   = 8'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (data_rvalid_i) begin
                    rsp      = 1'b1;
                    rsp_data = data_rdata_i;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Give up: hand the owner an empty response and flag it.
                    rsp     = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are forced low while reset is held, even though the request path is combinational.
    assign live = ~rst_i;

    assign m0_gnt_o     = live & grant & ~win;
    assign m1_gnt_o     = live & grant & win;
    assign m0_rvalid_o  = live & rsp & ~owner_q;
    assign m1_rvalid_o  = live & rsp & owner_q;
    assign m0_rdata_o   = m0_rvalid_o ? rsp_data : '0;
    assign m1_rdata_o   = m1_rvalid_o ? rsp_data : '0;

    assign data_req_o   = live & grant;
    assign data_we_o    = data_req_o & (win ? m1_we_i : m0_we_i);
    assign data_be_o    = data_req_o ? (win ? m1_be_i    : m0_be_i)    : '0;
    assign data_addr_o  = data_req_o ? (win ? m1_addr_i  : m0_addr_i)  : '0;
    assign data_wdata_o = data_req_o ? (win ? m1_wdata_i : m0_wdata_i) : '0;

    assign err_o        = live & err;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Latency: inputs change 1 ns after the rising edge; combinational outputs are sampled on the falling edge.
// Backpressure: bench masters hold req until granted; the bench slave answers 1..TIMEOUT cycles after a grant.
module tb_rv_mem_arbiter;
    import rv_pkg::*;

    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [XLEN/8-1:0] m0_be, m1_be;
    logic [XLEN-1:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [XLEN-1:0]   m0_rdata, m1_rdata;
    logic              data_req, data_we, data_rvalid, err;
    logic [XLEN/8-1:0] data_be;
    logic [XLEN-1:0]   data_addr, data_wdata, data_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be), .data_addr_o(data_addr),
        .data_wdata_o(data_wdata), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
        .err_o(err)
    );

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
        data_rvalid = 0; data_rdata = '0;
    endtask

    // Leaves the bench 1 ns after a rising edge with reset released.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        m0_req = 1; m1_req = 1; data_rvalid = 1; data_rdata = 32'hFFFF_FFFF;
        m0_addr = 32'h1111_1111; m1_addr = 32'h2222_2222;
        #3;
        checks++;
        if ({m0_gnt, m1_gnt, data_req} !== 3'b000) begin
            errors++; $display("FAIL rst_gnt: got %b required 000", {m0_gnt, m1_gnt, data_req});
        end
        checks++;
        if ({m0_rvalid, m1_rvalid, err, m0_rdata, m1_rdata, data_we, data_be, data_addr, data_wdata} !== '0) begin
            errors++; $display("FAIL rst_outputs: some output nonzero during reset");
        end
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, data_req, m0_rvalid, m1_rvalid, err, data_addr, data_be} !== '0) begin
            errors++; $display("FAIL idle_outputs: some output nonzero in IDLE with no request");
        end
    endtask

    task automatic test_single_read();
        do_reset();
        m0_req = 1; m0_we = 0; m0_be = 4'hF; m0_addr = 32'h0000_0010;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, data_req, data_we} !== 4'b1010) begin
            errors++; $display("FAIL rd_grant: got %b required 1010", {m0_gnt, m1_gnt, data_req, data_we});
        end
        checks++;
        if (data_addr !== 32'h0000_0010) begin
            errors++; $display("FAIL rd_addr: got %h required 00000010", data_addr);
        end
        @(posedge clk); #1;
        m0_req = 0; data_rvalid = 1; data_rdata = 32'hCAFE_0001;
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hCAFE_0001}) begin
            errors++; $display("FAIL rd_resp: got %b/%h required 1/cafe0001", m0_rvalid, m0_rdata);
        end
        checks++;
        if ({m1_gnt, m1_rvalid, m1_rdata, err} !== '0) begin
            errors++; $display("FAIL rd_m1_quiet: got %b/%b/%h/%b required all 0", m1_gnt, m1_rvalid, m1_rdata, err);
        end
        @(posedge clk); #1;
        data_rvalid = 0;
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m0_rdata} !== '0) begin
            errors++; $display("FAIL rd_after: got %b/%h required 0/0", m0_rvalid, m0_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        logic [1:0] exp_rv;
        do_reset();
        m0_req = 1; m0_addr = 32'hA000_0000;
        m1_req = 1; m1_addr = 32'hB000_0000;
        for (int i = 0; i < 12; i++) begin
            data_rvalid = (i % 2 == 1);
            data_rdata  = 32'(i);
            @(negedge clk);
            exp_g  = {(i % 4 == 2), (i % 4 == 0)};
            exp_rv = {(i % 4 == 3), (i % 4 == 1)};
            checks++;
            if ({m1_gnt, m0_gnt} !== exp_g) begin
                errors++; $display("FAIL rr_gnt cycle %0d: got %b required %b", i, {m1_gnt, m0_gnt}, exp_g);
            end
            checks++;
            if ({m1_rvalid, m0_rvalid} !== exp_rv) begin
                errors++; $display("FAIL rr_rvalid cycle %0d: got %b required %b", i, {m1_rvalid, m0_rvalid}, exp_rv);
            end
            if (exp_g == 2'b10) begin
                checks++;
                if (data_addr !== 32'hB000_0000) begin
                    errors++; $display("FAIL rr_addr cycle %0d: got %h required b0000000", i, data_addr);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write_m1();
        int n_rv  = 0;
        int n_req = 0;
        do_reset();
        m1_req = 1; m1_we = 1; m1_be = 4'b0011; m1_addr = 32'h2000_0040; m1_wdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({m1_gnt, m0_gnt, data_req, data_we, data_be, data_addr, data_wdata} !==
            {4'b1011, 4'b0011, 32'h2000_0040, 32'h1234_5678}) begin
            errors++; $display("FAIL wr_req: got gnt1=%b req=%b we=%b be=%b addr=%h wdata=%h",
                               m1_gnt, data_req, data_we, data_be, data_addr, data_wdata);
        end
        n_req += int'(data_req);
        n_rv  += int'(m1_rvalid);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            m1_req = 0; m0_req = 1; m0_addr = 32'h0000_0444;
            data_rvalid = (k == 3); data_rdata = 32'h5555_AAAA;
            @(negedge clk);
            n_rv += int'(m1_rvalid);
            if (k < 4) begin
                n_req += int'(data_req);
                checks++;
                if ({m0_gnt, m1_gnt, data_req, data_we, data_be} !== '0) begin
                    errors++; $display("FAIL wr_busy cycle %0d: got gnt=%b%b req=%b required 0", k, m1_gnt, m0_gnt, data_req);
                end
            end else begin
                checks++;
                if ({m0_gnt, data_addr} !== {1'b1, 32'h0000_0444}) begin
                    errors++; $display("FAIL wr_next_grant: got %b/%h required 1/00000444", m0_gnt, data_addr);
                end
            end
        end
        checks++;
        if (n_rv !== 1) begin
            errors++; $display("FAIL wr_rvalid_count: got %0d required 1", n_rv);
        end
        checks++;
        if (n_req !== 1) begin
            errors++; $display("FAIL wr_req_count: got %0d required 1", n_req);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        m0_req = 1; m0_addr = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++; $display("FAIL to_grant: got %b required 1", m0_gnt);
        end
        for (int k = 1; k <= TO; k++) begin
            @(posedge clk); #1;
            m0_req = 0;
            @(negedge clk);
            checks++;
            if ({m0_rvalid, err, m0_rdata} !== {(k == TO), (k == TO), 32'h0}) begin
                errors++; $display("FAIL to_busy cycle %0d: got rv=%b err=%b rdata=%h required %b/%b/0",
                                   k, m0_rvalid, err, m0_rdata, (k == TO), (k == TO));
            end
        end
        @(posedge clk); #1;
        data_rvalid = 1; data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({err, m0_rvalid, m1_rvalid, data_req, m0_rdata} !== {4'b1000, 32'h0}) begin
            errors++; $display("FAIL to_stale: got err=%b rv=%b%b req=%b required err only", err, m1_rvalid, m0_rvalid, data_req);
        end
        @(posedge clk); #1;
        m1_req = 1; m1_addr = 32'h0000_0200;
        @(negedge clk);
        checks++;
        if ({m1_gnt, err, m1_rvalid, data_addr} !== {3'b110, 32'h0000_0200}) begin
            errors++; $display("FAIL to_stale_grant: got gnt=%b err=%b rv=%b addr=%h required 1/1/0/00000200",
                               m1_gnt, err, m1_rvalid, data_addr);
        end
        @(posedge clk); #1;
        m1_req = 0; data_rvalid = 0;
        @(negedge clk);
        checks++;
        if ({err, m1_rvalid, m1_gnt} !== 3'b000) begin
            errors++; $display("FAIL to_quiet: got %b required 000", {err, m1_rvalid, m1_gnt});
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        m0_req = 1;
        @(negedge clk);
        @(posedge clk); #1;
        m0_req = 0; m1_req = 1;
        #2 rst = 1'b1;
        data_rvalid = 1; data_rdata = 32'h7777_7777;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, err, data_req, m0_rdata, m1_rdata} !== '0) begin
            errors++; $display("FAIL mid_rst: outputs nonzero during reset, gnt=%b%b rv=%b%b err=%b",
                               m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, err);
        end
        @(posedge clk); #1;
        rst = 1'b0; m1_req = 0; data_rvalid = 1;
        @(negedge clk);
        checks++;
        if ({err, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt} !== 5'b10000) begin
            errors++; $display("FAIL mid_stale: got %b required 10000", {err, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt});
        end
        @(posedge clk); #1;
        data_rvalid = 0; m1_req = 1;
        @(negedge clk);
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b10) begin
            errors++; $display("FAIL mid_m1_first: got %b required 10", {m1_gnt, m0_gnt});
        end
    endtask

    // Transaction-level model: one job in flight, fair choice on contention, bench slave answers in 1..TO cycles.
    task automatic test_random(input int cycles);
        logic              mreq  [2];
        logic              mwe   [2];
        logic [XLEN/8-1:0] mbe   [2];
        logic [XLEN-1:0]   maddr [2];
        logic [XLEN-1:0]   mwd   [2];
        bit                busy  = 0;
        bit                owner = 0;
        bit                last  = 1;
        bit                win;
        int                due   = 0;
        logic [1:0]        exp_g, exp_rv;
        bit                exp_err;
        do_reset();
        for (int m = 0; m < 2; m++) begin
            mreq[m] = 0; mwe[m] = 0; mbe[m] = '0; maddr[m] = '0; mwd[m] = '0;
        end
        for (int c = 0; c < cycles; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!mreq[m] && $urandom_range(0, 2) == 0) begin
                    mreq[m] = 1; mwe[m] = 1'($urandom); mbe[m] = 4'($urandom);
                    maddr[m] = $urandom; mwd[m] = $urandom;
                end
            end
            data_rvalid = 0;
            data_rdata  = $urandom;
            if (busy) begin
                due--;
                data_rvalid = (due == 0);
            end else begin
                data_rvalid = ($urandom_range(0, 15) == 0);
            end
            m0_req = mreq[0]; m0_we = mwe[0]; m0_be = mbe[0]; m0_addr = maddr[0]; m0_wdata = mwd[0];
            m1_req = mreq[1]; m1_we = mwe[1]; m1_be = mbe[1]; m1_addr = maddr[1]; m1_wdata = mwd[1];
            @(negedge clk);
            exp_g = 2'b00;
            win   = 0;
            if (!busy && (mreq[0] || mreq[1])) begin
                win = (mreq[0] && mreq[1]) ? (last ? 1'b0 : 1'b1) : mreq[1];
                exp_g[win] = 1'b1;
            end
            exp_rv  = (busy && data_rvalid) ? (owner ? 2'b10 : 2'b01) : 2'b00;
            exp_err = !busy && data_rvalid;
            checks++;
            if ({m1_gnt, m0_gnt, data_req} !== {exp_g, (exp_g != 0)}) begin
                errors++; $display("FAIL rnd_gnt cycle %0d: got %b%b req=%b required %b", c, m1_gnt, m0_gnt, data_req, exp_g);
            end
            checks++;
            if (exp_g != 0) begin
                if ({data_we, data_be, data_addr, data_wdata} !== {mwe[win], mbe[win], maddr[win], mwd[win]}) begin
                    errors++; $display("FAIL rnd_fields cycle %0d: got addr=%h wdata=%h required addr=%h wdata=%h",
                                       c, data_addr, data_wdata, maddr[win], mwd[win]);
                end
            end else if ({data_we, data_be, data_addr, data_wdata} !== '0) begin
                errors++; $display("FAIL rnd_fields cycle %0d: slave fields nonzero with no request, addr=%h", c, data_addr);
            end
            checks++;
            if ({m1_rvalid, m0_rvalid} !== exp_rv) begin
                errors++; $display("FAIL rnd_rvalid cycle %0d: got %b required %b", c, {m1_rvalid, m0_rvalid}, exp_rv);
            end
            checks++;
            if ({m0_rdata, m1_rdata} !== {(exp_rv[0] ? data_rdata : 32'h0), (exp_rv[1] ? data_rdata : 32'h0)}) begin
                errors++; $display("FAIL rnd_rdata cycle %0d: got %h/%h", c, m0_rdata, m1_rdata);
            end
            checks++;
            if (err !== exp_err) begin
                errors++; $display("FAIL rnd_err cycle %0d: got %b required %b", c, err, exp_err);
            end
            if (busy && data_rvalid) begin
                busy = 0;
            end else if (exp_g != 0) begin
                busy = 1; owner = win; last = win; mreq[win] = 0;
                due = $urandom_range(1, TO);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_m1();
        test_timeout();
        test_reset_mid_busy();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_mem_arbiter.md
RV_MEM_ARBITER -- requirements
Module: rv_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum BUSY cycles to wait for slave rvalid; legal range 2..255.
REQ-002 SHALL take XLEN from rv_pkg.
REQ-003 SHALL run on one clock, clk_i; reset rst_i is asynchronous and active-high.
REQ-004 clk_i  input  1  system clock.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 mX_req_i  input  1  master X (X=0 core LSU, X=1 loader/DMA) request.
REQ-007 mX_we_i  input  1  master X write enable.
REQ-008 mX_be_i  input  XLEN/8  master X byte enables.
REQ-009 mX_addr_i  input  XLEN  master X address.
REQ-010 mX_wdata_i  input  XLEN  master X write data.
REQ-011 mX_gnt_o  output  1  master X request accepted this cycle.
REQ-012 mX_rvalid_o  output  1  master X response valid.
REQ-013 mX_rdata_o  output  XLEN  master X read data.
REQ-014 data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o  output  1/1/XLEN/8/XLEN/XLEN  slave-side request toward the MMU.
REQ-015 data_rvalid_i  input  1  slave response valid; data_rdata_i  input  XLEN  slave read data.
REQ-016 err_o  output  1  one-cycle pulse on timeout or on a spurious slave rvalid.

Function
REQ-017 SHALL implement FSM states IDLE and BUSY; one transaction outstanding at most.
REQ-018 Slave protocol:
  - slave accepts data_req_o in the cycle it is high;
  - slave returns exactly one data_rvalid_i, 1..n cycles later, for every read and every write.
REQ-019 IDLE, exactly one mX_req_i high:
  - that master wins;
  - mX_gnt_o=1 combinationally in the same cycle;
  - data_req_o=1 with we/be/addr/wdata muxed from the winner;
  - owner register := X; next state BUSY.
REQ-020 IDLE, both requests high:
  - round-robin; the master not granted last wins;
  - last-granted register resets to 1, so m0 wins the first contention.
REQ-021 IDLE, no request: data_req_o=0, all slave-side request fields 0, both gnt 0.
REQ-022 BUSY:
  - data_req_o=0, both gnt 0;
  - master requests are held off, not queued; masters keep req high until gnt.
REQ-023 BUSY with data_rvalid_i=1:
  - owner's mX_rvalid_o=1 and mX_rdata_o=data_rdata_i in the same cycle (combinational path);
  - next state IDLE; earliest new grant is the following cycle.
REQ-024 Non-owner rvalid SHALL be 0; rdata outputs SHALL be 0 whenever the corresponding rvalid is 0.
REQ-025 Timeout counter:
  - 8 bits; cleared on entering BUSY; increments each BUSY cycle without rvalid;
  - when it reaches TIMEOUT-1 with no rvalid: owner rvalid=1, rdata=0, err_o=1 for that cycle, next state IDLE.
REQ-026 Stale response: a data_rvalid_i arriving after a timeout, or any data_rvalid_i in IDLE, SHALL be dropped and SHALL pulse err_o for one cycle without affecting the FSM.
REQ-027 If a stale rvalid and a new request coincide in IDLE, the grant SHALL proceed normally and err_o SHALL pulse.
REQ-028 Sustained throughput SHALL be one transaction per (slave latency + 1) cycles.

Reset
REQ-029 rst_i high SHALL force, asynchronously: state IDLE, owner 0, last-granted 1, counter 0; all outputs 0.
REQ-030 Reset mid-BUSY SHALL abandon the transaction; a later slave rvalid is treated as stale per REQ-026.

Verification
REQ-031 m0 read, addr 0x0000_0010, slave rvalid 1 cycle later with rdata 0xCAFE_0001 -> m0_gnt_o=1 in cycle 0, m0_rvalid_o=1 with 0xCAFE_0001 in cycle 1, m1 outputs 0.
REQ-032 m0 and m1 request continuously, 1-cycle slave -> grants alternate m0,m1,m0,m1 every 2 cycles, starting with m0.
REQ-033 m1 write, be=4'b0011, wdata 0x1234_5678, slave rvalid after 3 cycles -> data_* outputs match for exactly 1 cycle, m1_rvalid_o exactly once, no grant during BUSY.
REQ-034 TIMEOUT=4, slave never answers -> owner rvalid=1 with rdata 0 and err_o=1 on the 4th BUSY cycle (counter 3), then IDLE; a late slave rvalid -> err_o pulse only.
REQ-035 rst_i asserted in the middle of a BUSY cycle -> all outputs 0 immediately; after release, a pending m1 request is granted first (last-granted=1 rule still gives m0 priority only on contention).
